// File: rtl/mysystem_pio_pkg.sv
// Shared constants for the PIO input block: Avalon register word addresses
// and the encodings of the EDGE_TYPE parameter.
package mysystem_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage : mysystem_pio_pkg

// File: rtl/mysystem_pio_sync.sv
// Multi-flop synchronizer for the asynchronous PIO inputs, plus a one-cycle
// delayed copy of the synchronized value used for edge detection.
module mysystem_pio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] prev_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // NOTE: every flop here is reset, prev_q included, so sync_o and prev_o
  // leave reset equal and no spurious edge is seen on the first cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the old value
      // of its predecessor, giving a true shift chain regardless of order.
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign prev_o = prev_q;

endmodule : mysystem_pio_sync

// File: rtl/mysystem_pio_in.sv
// Avalon-MM parallel input port: synchronized data register, interrupt mask,
// sticky write-1-to-clear edge capture and a level interrupt.
module mysystem_pio_in
  import mysystem_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_w, prev_w, edge_w;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  mysystem_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (in_port),
    .sync_o  (sync_w),
    .prev_o  (prev_w)
  );

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect &  write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    if (EDGE_TYPE == EDGE_FALLING)  edge_w = ~sync_w & prev_w;
    else if (EDGE_TYPE == EDGE_ANY) edge_w =  sync_w ^ prev_w;
    else                            edge_w =  sync_w & ~prev_w;
  end

  // NOTE: each next-state value starts from its register so no path through
  // this block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    irqmask_d  = irqmask_q;
    edgecap_d  = edgecap_q;
    readdata_d = readdata_q;

    if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    // Applied after the clear so a coincident edge wins.
    edgecap_d = edgecap_d | edge_w;

    if (rd_en) begin
      case (address)
        ADDR_DATA:    readdata_d = 32'(sync_w);
        ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
        ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule : mysystem_pio_in

// File: tb/tb_mysystem_pio_in.sv
// Self-checking bench: a rising-edge and an any-edge instance share one bus;
// reads are scored through a queue of expected values.
module tb_mysystem_pio_in;
  import mysystem_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [15:0] in_port = '0;
  logic [31:0] rd_rise, rd_any;
  logic        irq_rise, irq_any;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] exp_rise;
    logic [31:0] exp_any;
  } rd_exp_t;
  rd_exp_t sb[$];

  typedef struct {
    logic [15:0] in_val;
    logic [15:0] cap_rise;
    logic [15:0] cap_any;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mysystem_pio_in #(.WIDTH(16), .EDGE_TYPE(EDGE_RISING), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  mysystem_pio_in #(.WIDTH(16), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_any), .irq(irq_any)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic compare_pop();
    rd_exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check({e.name, "/rise"}, rd_rise, e.exp_rise);
      check({e.name, "/any"},  rd_any,  e.exp_any);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, input string name,
                          input logic [31:0] er, input logic [31:0] ea);
    address = addr; chipselect = 1'b1; write_n = 1'b1;
    sb.push_back('{name, er, ea});
    tick();
    chipselect = 1'b0;
    compare_pop();
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // in_val, expected rising capture, expected any-edge capture (from previous value)
    vecs[0] = '{16'h0001, 16'h0001, 16'h0001};
    vecs[1] = '{16'h00F0, 16'h00F0, 16'h00F1};
    vecs[2] = '{16'h0F00, 16'h0F00, 16'h0FF0};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0F00};
    vecs[4] = '{16'hA5A5, 16'hA5A5, 16'hA5A5};
    vecs[5] = '{16'h5A5A, 16'h5A5A, 16'hFFFF};
    vecs[6] = '{16'hFFFF, 16'hA5A5, 16'hA5A5};
    vecs[7] = '{16'h0000, 16'h0000, 16'hFFFF};

    // Reset values
    in_port = 16'hFFFF;
    repeat (3) tick();
    check("reset_readdata_rise", rd_rise, 32'h0);
    check("reset_irq_rise", irq_rise, 1'b0);
    reset_n = 1'b1;
    bus_read(ADDR_IRQMASK, "reset_irqmask", 32'h0, 32'h0);
    bus_read(ADDR_EDGECAP, "reset_edgecap", 32'h0, 32'h0);
    settle();
    bus_read(ADDR_DATA, "reset_data_synced", 32'h0000FFFF, 32'h0000FFFF);
    bus_read(ADDR_RSVD, "reserved_reads_0", 32'h0, 32'h0);
    check("reset_irq_any", irq_any, 1'b0);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    bus_read(ADDR_EDGECAP, "clear_all", 32'h0, 32'h0);
    in_port = 16'h0000;
    settle();
    bus_write(ADDR_EDGECAP, 32'hFFFF);

    // Table-driven capture patterns
    for (int i = 0; i < 8; i++) begin
      in_port = vecs[i].in_val;
      settle();
      bus_read(ADDR_EDGECAP, $sformatf("vec%0d_edgecap", i), vecs[i].cap_rise, vecs[i].cap_any);
      bus_read(ADDR_DATA, $sformatf("vec%0d_data", i), vecs[i].in_val, vecs[i].in_val);
      bus_write(ADDR_EDGECAP, 32'hFFFF);
    end

    // Rising capture latency: change before edge k, irq at edge k+2
    bus_write(ADDR_IRQMASK, 32'h0001);
    bus_read(ADDR_IRQMASK, "irqmask_rb", 32'h1, 32'h1);
    in_port = 16'h0001;
    tick();
    check("lat_k_irq", irq_rise, 1'b0);
    tick();
    check("lat_k1_irq", irq_rise, 1'b0);
    tick();
    check("lat_k2_irq_rise", irq_rise, 1'b1);
    check("lat_k2_irq_any", irq_any, 1'b1);
    bus_read(ADDR_EDGECAP, "lat_edgecap", 32'h1, 32'h1);
    bus_write(ADDR_EDGECAP, 32'h1);
    check("w1c_irq_rise", irq_rise, 1'b0);
    check("w1c_irq_any", irq_any, 1'b0);

    // Set beats clear on bit 3
    in_port = 16'h0009;
    tick();
    tick();
    bus_write(ADDR_EDGECAP, 32'h0008);
    bus_read(ADDR_EDGECAP, "set_beats_clear", 32'h8, 32'h8);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    bus_read(ADDR_EDGECAP, "clear_bit3", 32'h0, 32'h0);

    // Read coinciding with a new edge returns the pre-update value
    in_port = 16'h000B;
    tick();
    tick();
    bus_read(ADDR_EDGECAP, "read_pre_update", 32'h0, 32'h0);
    bus_read(ADDR_EDGECAP, "read_post_update", 32'h2, 32'h2);
    bus_write(ADDR_EDGECAP, 32'hFFFF);

    // Masking
    in_port = 16'h003B;
    settle();
    bus_write(ADDR_IRQMASK, 32'h000F);
    check("mask_off_irq_rise", irq_rise, 1'b0);
    check("mask_off_irq_any", irq_any, 1'b0);
    bus_read(ADDR_EDGECAP, "mask_edgecap", 32'h30, 32'h30);
    bus_write(ADDR_IRQMASK, 32'h0010);
    check("mask_on_irq_rise", irq_rise, 1'b1);
    check("mask_on_irq_any", irq_any, 1'b1);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    bus_write(ADDR_IRQMASK, 32'h0000);

    // Any-edge mode: bit 7 high then low, cleared between toggles
    in_port = 16'h00BB;
    settle();
    bus_read(ADDR_EDGECAP, "any_b7_rise", 32'h80, 32'h80);
    bus_write(ADDR_EDGECAP, 32'hFFFF);
    in_port = 16'h003B;
    settle();
    bus_read(ADDR_EDGECAP, "any_b7_fall", 32'h0, 32'h80);
    bus_write(ADDR_EDGECAP, 32'hFFFF);

    // Reset in the middle of an irqmask write with edgecapture nonzero
    in_port = 16'h0039;
    settle();
    in_port = 16'h003B;
    settle();
    bus_read(ADDR_EDGECAP, "pre_reset_edgecap", 32'h2, 32'h2);
    address = ADDR_IRQMASK; writedata = 32'hFFFF; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    check("midrst_readdata", rd_rise, 32'h0);
    reset_n = 1'b1;
    check("midrst_irq_rise", irq_rise, 1'b0);
    check("midrst_irq_any", irq_any, 1'b0);
    bus_read(ADDR_IRQMASK, "midrst_irqmask", 32'h0, 32'h0);
    bus_read(ADDR_EDGECAP, "midrst_edgecap", 32'h0, 32'h0);
    settle();
    check("midrst_no_partial_irq", irq_rise | irq_any, 1'b0);
    bus_read(ADDR_IRQMASK, "midrst_irqmask_late", 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mysystem_pio_in
